// File: rtl/viterbi_stage_sequencer_pkg.sv
// Shared types and constants for the Viterbi stage sequencer.
// State encoding, metric/decision widths and the stage latency default.
package viterbi_pkg;

    localparam int MET_W         = 8;
    localparam int DEC_W         = 8;
    localparam int STAGE_LAT_DEF = 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CAPT  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_RECV  = S_RECV,
        ST_WAIT  = S_WAIT,
        ST_CAPT  = S_CAPT,
        ST_DRAIN = S_DRAIN
    } seq_state_e;

    // Signed minimum; a tie returns the first operand.
    function automatic logic [MET_W-1:0] smin(
        input logic [MET_W-1:0] a,
        input logic [MET_W-1:0] b
    );
        return ($signed(b) < $signed(a)) ? b : a;
    endfunction

endpackage

// File: rtl/viterbi_stage_sequencer_if.sv
// Symbol-in and decision-out handshake channels of the sequencer.
// The slave side is the sequencer, the master side is its environment.
interface viterbi_stage_sequencer_if;
    import viterbi_pkg::*;

    logic             sym_valid;
    logic             sym_ready;
    logic [MET_W-1:0] sym_r3;
    logic [MET_W-1:0] sym_r4;

    logic             dec_valid;
    logic             dec_ready;
    logic [DEC_W-1:0] dec_data;
    logic             dec_last;

    modport master (
        output sym_valid, sym_r3, sym_r4, dec_ready,
        input  sym_ready, dec_valid, dec_data, dec_last
    );

    modport slave (
        input  sym_valid, sym_r3, sym_r4, dec_ready,
        output sym_ready, dec_valid, dec_data, dec_last
    );

endinterface

// File: rtl/viterbi_stage_sequencer_dec_buf.sv
// Per-frame decision store: one synchronous write, one combinational read.
// Contents are not reset; every entry is written before it is drained.
module viterbi_dec_buf
    import viterbi_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = DEC_W
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/viterbi_stage_sequencer.sv
// Runs one butterfly stage over a frame of symbol pairs, tracking path
// metrics, then streams the stored decision nibbles to traceback.
module viterbi_stage_sequencer
    import viterbi_pkg::*;
#(
    parameter int               FRAME_LEN   = 16,
    parameter int               STAGE_LAT   = STAGE_LAT_DEF,
    parameter logic [MET_W-1:0] INIT_MET_11 = 8'h40,
    parameter bit               NORM_EN     = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    viterbi_stage_sequencer_if.slave bus,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic [MET_W-1:0]         stg_r3_o,
    output logic [MET_W-1:0]         stg_r4_o,
    output logic [MET_W-1:0]         stg_edge_00_o,
    output logic [MET_W-1:0]         stg_edge_11_o,
    input  logic [MET_W-1:0]         stg_survivor_00_i,
    input  logic [MET_W-1:0]         stg_survivor_11_i,
    input  logic [3:0]               stg_c0_i,
    input  logic [3:0]               stg_c1_i,
    output logic                     final_state_o,
    output logic                     frame_done_o
);

    localparam int AW = $clog2(FRAME_LEN);
    localparam int WW = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;
    localparam logic [AW-1:0] LAST_IDX  = AW'(FRAME_LEN - 1);
    localparam logic [WW-1:0] LAST_WAIT = WW'(STAGE_LAT - 1);

    seq_state_e       state_q;
    logic [AW-1:0]    idx_q;
    logic [AW-1:0]    rd_q;
    logic [WW-1:0]    wait_q;
    logic [MET_W-1:0] r3_q, r4_q;
    logic [MET_W-1:0] m00_q, m11_q;
    logic [MET_W-1:0] m00_d, m11_d;
    logic [MET_W-1:0] mn;
    logic             fin_q, done_q;
    logic             busy_q, rdy_q, dvld_q;
    logic [DEC_W-1:0] rdata;

    // Renormalise so the better survivor sits at zero; wrap is accepted.
    always_comb begin
        mn    = smin(stg_survivor_00_i, stg_survivor_11_i);
        m00_d = stg_survivor_00_i;
        m11_d = stg_survivor_11_i;
        if (NORM_EN) begin
            m00_d = stg_survivor_00_i - mn;
            m11_d = stg_survivor_11_i - mn;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rd_q    <= '0;
            wait_q  <= '0;
            r3_q    <= '0;
            r4_q    <= '0;
            m00_q   <= '0;
            m11_q   <= INIT_MET_11;
            fin_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            dvld_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_RECV;
                        m00_q   <= '0;
                        m11_q   <= INIT_MET_11;
                        idx_q   <= '0;
                        fin_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        rdy_q   <= 1'b1;
                    end
                end
                ST_RECV: begin
                    if (bus.sym_valid) begin
                        r3_q    <= bus.sym_r3;
                        r4_q    <= bus.sym_r4;
                        wait_q  <= '0;
                        rdy_q   <= 1'b0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_q <= wait_q + 1'b1;
                    if (wait_q == LAST_WAIT) begin
                        state_q <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    m00_q <= m00_d;
                    m11_q <= m11_d;
                    if (idx_q == LAST_IDX) begin
                        fin_q   <= $signed(stg_survivor_11_i)
                                 < $signed(stg_survivor_00_i);
                        rd_q    <= '0;
                        dvld_q  <= 1'b1;
                        state_q <= ST_DRAIN;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        rdy_q   <= 1'b1;
                        state_q <= ST_RECV;
                    end
                end
                ST_DRAIN: begin
                    if (bus.dec_ready) begin
                        if (rd_q == LAST_IDX) begin
                            dvld_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            rd_q <= rd_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    rdy_q   <= 1'b0;
                    dvld_q  <= 1'b0;
                end
            endcase
        end
    end

    viterbi_dec_buf #(
        .DEPTH (FRAME_LEN),
        .AW    (AW),
        .DW    (DEC_W)
    ) u_buf (
        .clk_i   (clk_i),
        .we_i    (state_q == ST_CAPT),
        .waddr_i (idx_q),
        .wdata_i ({stg_c1_i, stg_c0_i}),
        .raddr_i (rd_q),
        .rdata_o (rdata)
    );

    assign bus.sym_ready = rdy_q;
    assign bus.dec_valid = dvld_q;
    assign bus.dec_data  = dvld_q ? rdata : '0;
    assign bus.dec_last  = dvld_q && (rd_q == LAST_IDX);

    assign busy_o        = busy_q;
    assign stg_r3_o      = r3_q;
    assign stg_r4_o      = r4_q;
    assign stg_edge_00_o = m00_q;
    assign stg_edge_11_o = m11_q;
    assign final_state_o = fin_q;
    assign frame_done_o  = done_q;

endmodule

// File: tb/tb_viterbi_stage_sequencer.sv
// Directed and randomised frames against a stage stand-in and a metric model.
module tb_viterbi_stage_sequencer;
    import viterbi_pkg::*;

    localparam int FL = 16;
    localparam int SL = 4;
    localparam logic [7:0] INIT11 = 8'h40;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    viterbi_stage_sequencer_if sif ();

    logic       start, busy, fin, done;
    logic [7:0] stg_r3, stg_r4, e00, e11, s00, s11;
    logic [3:0] c0, c1;

    viterbi_stage_sequencer #(
        .FRAME_LEN   (FL),
        .STAGE_LAT   (SL),
        .INIT_MET_11 (INIT11),
        .NORM_EN     (1'b1)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .bus               (sif),
        .start_i           (start),
        .busy_o            (busy),
        .stg_r3_o          (stg_r3),
        .stg_r4_o          (stg_r4),
        .stg_edge_00_o     (e00),
        .stg_edge_11_o     (e11),
        .stg_survivor_00_i (s00),
        .stg_survivor_11_i (s11),
        .stg_c0_i          (c0),
        .stg_c1_i          (c1),
        .final_state_o     (fin),
        .frame_done_o      (done)
    );

    typedef struct packed {
        logic [7:0] s00;
        logic [7:0] s11;
        logic [3:0] c1;
        logic [3:0] c0;
    } stg_t;

    // Stand-in butterfly: arbitrary arithmetic, SL register stages deep.
    function automatic stg_t stage_fn(
        input logic [7:0] r3, input logic [7:0] r4,
        input logic [7:0] m0, input logic [7:0] m1,
        input logic oe, input logic [7:0] o0, input logic [7:0] o1
    );
        stg_t t;
        t.s00 = oe ? o0 : m0 + (r3 ^ r4);
        t.s11 = oe ? o1 : m1 + (r3 - r4);
        t.c0  = r3[3:0] ^ m0[3:0];
        t.c1  = r4[3:0] + m1[3:0];
        return t;
    endfunction

    stg_t       pipe [SL];
    logic       ovr_en = 1'b0;
    logic [7:0] ovr00 = 8'h00;
    logic [7:0] ovr11 = 8'h00;

    always @(posedge clk) begin
        pipe[0] <= stage_fn(stg_r3, stg_r4, e00, e11, ovr_en, ovr00, ovr11);
        for (int i = 1; i < SL; i++) pipe[i] <= pipe[i-1];
    end

    assign s00 = pipe[SL-1].s00;
    assign s11 = pipe[SL-1].s11;
    assign c1  = pipe[SL-1].c1;
    assign c0  = pipe[SL-1].c0;

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] m00, m11;
    logic [7:0] exp_dec [FL];
    logic       exp_fin;
    int         idx;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m00 = 8'h00;
        m11 = INIT11;
        idx = 0;
        chk("start_busy", busy, 1);
        chk("start_ready", sif.sym_ready, 1);
        chk("start_e00", e00, 8'h00);
        chk("start_e11", e11, INIT11);
    endtask

    task automatic send(input logic [7:0] r3, input logic [7:0] r4,
                        input bit oe, input logic [7:0] o0,
                        input logic [7:0] o1, input bit abuse);
        stg_t       t;
        logic [7:0] mn;
        int         w;
        bit         last;
        last = (idx == FL - 1);
        t = stage_fn(r3, r4, m00, m11, oe, o0, o1);
        ovr_en = oe;
        ovr00 = o0;
        ovr11 = o1;
        sif.sym_valid = 1'b1;
        sif.sym_r3 = r3;
        sif.sym_r4 = r4;
        w = 0;
        while (sif.sym_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept_timeout", w < 50, 1);
        @(negedge clk);
        chk("stg_r3", stg_r3, r3);
        chk("stg_r4", stg_r4, r4);
        chk("ready_drop", sif.sym_ready, 0);
        if (abuse) begin
            sif.sym_r3 = ~r3;
            sif.sym_r4 = r4 + 8'd1;
            start = 1'b1;
        end else begin
            sif.sym_valid = 1'b0;
        end
        repeat (SL) @(negedge clk);
        chk("hold_e00", e00, m00);
        chk("hold_e11", e11, m11);
        chk("hold_r3", stg_r3, r3);
        chk("wait_ready", sif.sym_ready, 0);
        sif.sym_valid = 1'b0;
        start = 1'b0;
        mn = ($signed(t.s11) < $signed(t.s00)) ? t.s11 : t.s00;
        exp_dec[idx] = {t.c1, t.c0};
        if (last) exp_fin = $signed(t.s11) < $signed(t.s00);
        m00 = t.s00 - mn;
        m11 = t.s11 - mn;
        @(negedge clk);
        chk("capt_e00", e00, m00);
        chk("capt_e11", e11, m11);
        chk("capt_ready", sif.sym_ready, !last);
        chk("capt_dvalid", sif.dec_valid, last);
        if (last) chk("final_state", fin, exp_fin);
        idx++;
        ovr_en = 1'b0;
    endtask

    task automatic drain(input bit toggle, input bit poke_start);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < FL && cyc < 200) begin
            sif.dec_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            start = poke_start && (cyc == 2);
            chk("dec_valid", sif.dec_valid, 1);
            chk("dec_data", sif.dec_data, exp_dec[got]);
            chk("dec_last", sif.dec_last, got == FL - 1);
            chk("done_early", done, 0);
            if (sif.dec_ready) got++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        sif.dec_ready = 1'b0;
        chk("drain_count", got, FL);
        chk("frame_done", done, 1);
        chk("drain_idle", busy, 0);
        chk("drain_dvalid", sif.dec_valid, 0);
        chk("final_hold", fin, exp_fin);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("still_idle", busy, 0);
    endtask

    initial begin
        sif.sym_valid = 1'b0;
        sif.sym_r3 = 8'h00;
        sif.sym_r4 = 8'h00;
        sif.dec_ready = 1'b0;
        start = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready", sif.sym_ready, 0);
        chk("rst_dvalid", sif.dec_valid, 0);
        chk("rst_e00", e00, 8'h00);
        chk("rst_e11", e11, INIT11);
        chk("rst_r3", stg_r3, 8'h00);
        chk("rst_done", done, 0);
        chk("rst_final", fin, 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_wins", busy, 0);

        // Abort a frame while the stage pipeline is busy.
        do_start();
        sif.sym_valid = 1'b1;
        sif.sym_r3 = 8'h55;
        @(negedge clk);
        sif.sym_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_wait_ready", sif.sym_ready, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_ready", sif.sym_ready, 0);
        chk("abort_dvalid", sif.dec_valid, 0);
        chk("abort_e11", e11, INIT11);
        sif.sym_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_accept", sif.sym_ready, 0);
        chk("idle_no_busy", busy, 0);
        chk("idle_r3", stg_r3, 8'h00);
        sif.sym_valid = 1'b0;

        // Directed frame with normalisation and misuse cases.
        do_start();
        send(8'h10, 8'h10, 0, 8'h00, 8'h00, 0);
        send(8'h21, 8'h07, 1, 8'h30, 8'h10, 0);
        chk("norm_e00", e00, 8'h20);
        chk("norm_e11", e11, 8'h00);
        send(8'($urandom), 8'($urandom), 0, 8'h00, 8'h00, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("recv_start_busy", busy, 1);
        chk("recv_start_e00", e00, m00);
        chk("recv_start_e11", e11, m11);
        for (int i = 3; i < FL - 1; i++)
            send(8'($urandom), 8'($urandom), 0, 8'h00, 8'h00, 0);
        send(8'($urandom), 8'($urandom), 1, 8'hF0, 8'h05, 0);
        chk("final_zero", fin, 0);
        drain(1, 1);

        // Random frame ending with state 11 winning.
        do_start();
        for (int i = 0; i < FL - 1; i++) begin
            if (i == 5)
                send(8'($urandom), 8'($urandom), 1, 8'h22, 8'h22, 0);
            else if ($urandom_range(0, 3) == 0)
                send(8'($urandom), 8'($urandom), 1,
                     8'($urandom), 8'($urandom), 0);
            else
                send(8'($urandom), 8'($urandom), 0, 8'h00, 8'h00, 0);
        end
        send(8'($urandom), 8'($urandom), 1, 8'h05, 8'hF0, 0);
        chk("final_one", fin, 1);
        drain(0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
